// File: rtl/canvas_buffer.sv
// canvas_buffer: W x H intensity canvas with brush stamp, clear sweep, display read
// port and valid/ready raster stream. Optional drop counter: CANVAS_DROP_CNT_EN.
module canvas_buffer #(
  parameter int W = 28,
  parameter int H = 28,
  parameter int PIX_W = 16,
  parameter int COORD_W = 10,
  parameter int ORIGIN_X = 0,
  parameter int ORIGIN_Y = 0,
  parameter int CELL_LOG2 = 3,
  parameter int BRUSH_R = 1,
  parameter logic [PIX_W-1:0] INK_CENTER = 16'h4000,
  parameter logic [PIX_W-1:0] INK_EDGE = 16'h2000
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_vs,
  input  logic paint_en,
  input  logic erase_mode,
  input  logic clear_req,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic [$clog2(W)-1:0] rd_x,
  input  logic [$clog2(H)-1:0] rd_y,
  output logic [PIX_W-1:0] rd_data,
  input  logic stream_start,
  output logic s_valid,
  input  logic s_ready,
  output logic [PIX_W-1:0] s_data,
  output logic s_last,
  output logic busy,
  output logic [7:0] drop_cnt
);

  localparam int N = W * H;
  localparam int AW = $clog2(N);
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int F = 2 * BRUSH_R;
  localparam int FW = $clog2(F + 2);
  localparam int WH = (W > H) ? W : H;
  localparam int TW = $clog2(WH + F + 1);

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    STAMP
  } wstate_t;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } sstate_t;

  wstate_t state;
  sstate_t sstate;

  logic [PIX_W-1:0] mem [N];

  logic vs_d;
  logic tick;
  logic clr_pend;
  logic str_pend;
  logic idle_free;
  logic clear_go;
  logic stream_go;
  logic stamp_go;
  logic [AW-1:0] clr_idx;
  logic [AW-1:0] s_idx;
  logic [AW-1:0] s_nxt;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic er;
  logic [FW-1:0] dx;
  logic [FW-1:0] dy;

  logic [COORD_W-1:0] rel_x;
  logic [COORD_W-1:0] rel_y;
  logic [COORD_W-1:0] cell_x;
  logic [COORD_W-1:0] cell_y;
  logic hit;

  logic [TW-1:0] tx;
  logic [TW-1:0] ty;
  logic st_ok;
  logic [AW-1:0] st_addr;
  logic [PIX_W-1:0] cur;
  logic [PIX_W-1:0] ink;
  logic [PIX_W:0] sum;

  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [PIX_W-1:0] wr_data;

  logic rd_ok;
  logic [AW-1:0] rd_addr;

  assign tick = frame_vs & ~vs_d;

  assign rel_x = pos_x - COORD_W'(ORIGIN_X);
  assign rel_y = pos_y - COORD_W'(ORIGIN_Y);
  assign cell_x = rel_x >> CELL_LOG2;
  assign cell_y = rel_y >> CELL_LOG2;
  assign hit = (pos_x >= COORD_W'(ORIGIN_X))
            && (pos_y >= COORD_W'(ORIGIN_Y))
            && (cell_x < COORD_W'(W))
            && (cell_y < COORD_W'(H));

  // Stream and stamp/clear never overlap, so a started stream sees a frozen canvas.
  assign idle_free = (state == IDLE) && (sstate == S_IDLE);
  assign clear_go = idle_free && (clear_req || clr_pend);
  assign stream_go = idle_free && !clear_go
                  && (stream_start || str_pend);
  assign stamp_go = idle_free && !clear_go && !stream_go
                 && tick && paint_en && hit;

  // Footprint offset is biased by +R so edge cells are rejected without wrap.
  assign tx = TW'(cx) + TW'(dx);
  assign ty = TW'(cy) + TW'(dy);
  assign st_ok = (tx >= TW'(BRUSH_R)) && (tx < TW'(W + BRUSH_R))
              && (ty >= TW'(BRUSH_R)) && (ty < TW'(H + BRUSH_R));
  assign st_addr = AW'(ty - TW'(BRUSH_R)) * AW'(W)
                 + AW'(tx - TW'(BRUSH_R));
  assign cur = st_ok ? mem[st_addr] : '0;
  assign ink = (dx == FW'(BRUSH_R) && dy == FW'(BRUSH_R))
             ? INK_CENTER : INK_EDGE;
  assign sum = {1'b0, cur} + {1'b0, ink};

  always_comb begin
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    unique case (1'b1)
      (state == CLEAR): begin
        wr_en = 1'b1;
        wr_addr = clr_idx;
      end
      (state == STAMP && st_ok): begin
        wr_en = 1'b1;
        wr_addr = st_addr;
        if (!er)
          wr_data = sum[PIX_W] ? '1 : sum[PIX_W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  assign rd_ok = (32'(rd_x) < W) && (32'(rd_y) < H);
  assign rd_addr = AW'(rd_y) * AW'(W) + AW'(rd_x);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      rd_data <= '0;
    else if (rd_ok)
      rd_data <= mem[rd_addr];
    else
      rd_data <= '0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= CLEAR;
      clr_idx <= '0;
      vs_d <= 1'b0;
      clr_pend <= 1'b0;
      str_pend <= 1'b0;
      cx <= '0;
      cy <= '0;
      er <= 1'b0;
      dx <= '0;
      dy <= '0;
    end else begin
      vs_d <= frame_vs;
      if (clear_go)
        clr_pend <= 1'b0;
      else if (clear_req)
        clr_pend <= 1'b1;
      if (stream_go)
        str_pend <= 1'b0;
      else if (stream_start && sstate == S_IDLE)
        str_pend <= 1'b1;
      unique case (state)
        CLEAR: begin
          if (clr_idx == AW'(N - 1)) begin
            clr_idx <= '0;
            state <= IDLE;
          end else begin
            clr_idx <= clr_idx + AW'(1);
          end
        end
        IDLE: begin
          if (clear_go) begin
            clr_idx <= '0;
            state <= CLEAR;
          end else if (stamp_go) begin
            cx <= cell_x[XW-1:0];
            cy <= cell_y[YW-1:0];
            er <= erase_mode;
            dx <= '0;
            dy <= '0;
            state <= STAMP;
          end
        end
        STAMP: begin
          if (dx == FW'(F)) begin
            dx <= '0;
            if (dy == FW'(F))
              state <= IDLE;
            else
              dy <= dy + FW'(1);
          end else begin
            dx <= dx + FW'(1);
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign s_nxt = s_idx + AW'(1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sstate <= S_IDLE;
      s_valid <= 1'b0;
      s_last <= 1'b0;
      s_data <= '0;
      s_idx <= '0;
    end else begin
      unique case (sstate)
        S_IDLE: begin
          if (stream_go) begin
            sstate <= S_RUN;
            s_valid <= 1'b1;
            s_idx <= '0;
            s_data <= mem[0];
            s_last <= (N == 1);
          end
        end
        S_RUN: begin
          if (s_valid && s_ready) begin
            if (s_last) begin
              s_valid <= 1'b0;
              s_last <= 1'b0;
              sstate <= S_IDLE;
            end else begin
              s_idx <= s_nxt;
              s_data <= mem[s_nxt];
              s_last <= (s_nxt == AW'(N - 1));
            end
          end
        end
        default: sstate <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE) || (sstate == S_RUN)
             || clr_pend || str_pend;

`ifdef CANVAS_DROP_CNT_EN
  logic drop_ev;

  assign drop_ev = tick && paint_en
                && (!idle_free || clear_go || stream_go);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      drop_cnt <= '0;
    else if (clear_go)
      drop_cnt <= '0;
    else if (drop_ev && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_canvas_buffer.sv
// tb_canvas_buffer: randomized stimulus against a cell-array model; stream words
// are queued at request time and popped by an independent monitor.
`timescale 1ns/1ps
module tb_canvas_buffer;

  localparam int W = 28;
  localparam int H = 28;
  localparam int N = W * H;
  localparam int OX = 16;
  localparam int OY = 8;
  localparam int CL = 3;
  localparam int R = 1;
  localparam int INK_C = 'h4000;
  localparam int INK_E = 'h2000;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic frame_vs = 1'b0;
  logic paint_en = 1'b0;
  logic erase_mode = 1'b0;
  logic clear_req = 1'b0;
  logic [9:0] pos_x = '0;
  logic [9:0] pos_y = '0;
  logic [4:0] rd_x = '0;
  logic [4:0] rd_y = '0;
  logic [15:0] rd_data;
  logic stream_start = 1'b0;
  logic s_valid;
  logic s_ready = 1'b0;
  logic [15:0] s_data;
  logic s_last;
  logic busy;
  logic [7:0] drop_cnt;

  always #5 Clk = ~Clk;

  canvas_buffer #(
    .W(W), .H(H), .PIX_W(16), .COORD_W(10),
    .ORIGIN_X(OX), .ORIGIN_Y(OY), .CELL_LOG2(CL),
    .BRUSH_R(R)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .frame_vs(frame_vs), .paint_en(paint_en),
    .erase_mode(erase_mode), .clear_req(clear_req),
    .pos_x(pos_x), .pos_y(pos_y),
    .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .stream_start(stream_start), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [15:0] data;
    logic last;
  } word_t;

  int unsigned model [H][W];
  word_t sb[$];
  int checks = 0;
  int failures = 0;
  int ready_mode = 0;
  int exp_drop;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready changes just after the rising edge so the monitor sees a stable value.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      case (ready_mode)
        0: s_ready = 1'b0;
        1: s_ready = ~s_ready;
        2: s_ready = 1'($urandom_range(0, 1));
        default: s_ready = 1'b1;
      endcase
    end
  end

  initial begin
    logic pv, pr, pl, gap;
    logic [15:0] pd;
    word_t w;
    pv = 0; pr = 0; pl = 0; gap = 0; pd = 0;
    forever begin
      @(negedge Clk);
      if (Reset_n) begin
        if (gap) begin
          checks++;
          if (s_valid) begin
            failures++;
            $display("FAIL valid_after_last: s_valid=%0b expected 0", s_valid);
          end
          gap = 0;
        end
        if (pv && !pr) begin
          checks++;
          if (!s_valid || s_data != pd || s_last != pl) begin
            failures++;
            $display("FAIL stall_hold: v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                     s_valid, s_data, s_last, pd, pl);
          end
        end
        if (s_valid && s_ready) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL stream_extra: d=%0h expected no word", s_data);
          end else begin
            w = sb.pop_front();
            if (s_data != w.data || s_last != w.last) begin
              failures++;
              $display("FAIL stream_word: d=%0h l=%0b expected d=%0h l=%0b",
                       s_data, s_last, w.data, w.last);
            end
            if (s_last) gap = 1;
          end
        end
        pv = s_valid; pr = s_ready; pd = s_data; pl = s_last;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_clear();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        model[y][x] = 0;
  endfunction

  function automatic void model_stamp(input int cx, input int cy, input bit er);
    int x, y, v;
    for (int oy = -R; oy <= R; oy++)
      for (int ox = -R; ox <= R; ox++) begin
        x = cx + ox;
        y = cy + oy;
        if (x >= 0 && x < W && y >= 0 && y < H) begin
          v = int'(model[y][x]) + ((ox == 0 && oy == 0) ? INK_C : INK_E);
          model[y][x] = er ? 0 : ((v > 'hFFFF) ? 'hFFFF : v);
        end
      end
  endfunction

  function automatic bit to_cell(input int px, input int py,
                                 output int cx, output int cy);
    cx = (px - OX) >>> CL;
    cy = (py - OY) >>> CL;
    return px >= OX && py >= OY && cx < W && cy < H;
  endfunction

  function automatic void push_stream();
    word_t w;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        w.data = 16'(model[y][x]);
        w.last = (y == H - 1 && x == W - 1);
        sb.push_back(w);
      end
  endfunction

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge Clk);
      n++;
    end
    if (busy) check({name, "_idle_timeout"}, 1, 0);
  endtask

  task automatic wait_stream(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || s_valid) && n < 6000) begin
      @(negedge Clk);
      n++;
    end
    check({name, "_stream_left"}, sb.size(), 0);
    @(negedge Clk);
  endtask

  task automatic pulse_vs(input int px, input int py, input bit pe, input bit er);
    @(negedge Clk);
    pos_x = 10'(px);
    pos_y = 10'(py);
    paint_en = pe;
    erase_mode = er;
    frame_vs = 1'b1;
    @(negedge Clk);
    frame_vs = 1'b0;
  endtask

  task automatic paint(input int px, input int py, input bit pe, input bit er);
    int cx, cy;
    if (pe && to_cell(px, py, cx, cy)) model_stamp(cx, cy, er);
    pulse_vs(px, py, pe, er);
    wait_idle("paint");
  endtask

  function automatic int cell_px(input int c, input int org);
    return org + (c << CL) + int'($urandom_range(0, 7));
  endfunction

  task automatic do_clear();
    @(negedge Clk);
    clear_req = 1'b1;
    @(negedge Clk);
    clear_req = 1'b0;
    model_clear();
    wait_idle("clear");
  endtask

  task automatic start_stream(input int mode);
    ready_mode = mode;
    push_stream();
    @(negedge Clk);
    stream_start = 1'b1;
    @(negedge Clk);
    stream_start = 1'b0;
  endtask

  task automatic scan(input string name);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        rd_x = 5'(x);
        rd_y = 5'(y);
        @(negedge Clk);
        check(name, int'(rd_data), int'(model[y][x]));
      end
  endtask

  initial begin
    int n, cx, cy, px, py;
    bit pe, er;
    repeat (3) @(negedge Clk);
    check("rst_s_valid", int'(s_valid), 0);
    check("rst_s_last", int'(s_last), 0);
    check("rst_s_data", int'(s_data), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_drop_cnt", int'(drop_cnt), 0);
    check("rst_busy", int'(busy), 1);
    Reset_n = 1'b1;
    n = 0;
    while (n < 2000) begin
      @(negedge Clk);
      n++;
      if (!busy) break;
    end
    check("busy_fall_cycle", int'(n >= N && n <= N + 1), 1);
    model_clear();
    scan("after_reset");

    paint(cell_px(5, OX), cell_px(7, OY), 1, 0);
    scan("paint_1tick");
    repeat (4) paint(cell_px(5, OX), cell_px(7, OY), 1, 0);
    check("centre_sat", int'(model[7][5]), 'hFFFF);
    scan("paint_5tick");

    do_clear();
    paint(cell_px(0, OX), cell_px(0, OY), 1, 0);
    paint(cell_px(27, OX), cell_px(27, OY), 1, 0);
    scan("corners");

    start_stream(1);
    wait_stream("toggle");

    do_clear();
    paint(cell_px(5, OX), cell_px(7, OY), 1, 0);
    paint(cell_px(5, OX), cell_px(7, OY), 1, 0);
    paint(cell_px(5, OX), cell_px(7, OY), 1, 1);
    scan("erase");

    paint(cell_px(9, OX), cell_px(9, OY), 1, 0);
    pulse_vs(OX - 3, cell_px(4, OY), 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("below_origin_busy", int'(busy), 0);
    end

    for (int i = 0; i < 14; i++) begin
      px = int'($urandom_range(0, OX + W * 8 + 24));
      py = int'($urandom_range(0, OY + H * 8 + 24));
      if (i % 3 == 0) begin
        px = cell_px(int'($urandom_range(0, W - 1)), OX);
        py = cell_px(int'($urandom_range(0, H - 1)), OY);
      end
      pe = ($urandom_range(0, 7) != 0);
      er = ($urandom_range(0, 3) == 0);
      paint(px, py, pe, er);
    end
    scan("random");
    start_stream(2);
    wait_stream("random");

    start_stream(2);
    repeat (20) @(negedge Clk);
    clear_req = 1'b1;
    @(negedge Clk);
    clear_req = 1'b0;
    for (int i = 0; i < 3; i++)
      pulse_vs(cell_px(3, OX), cell_px(3, OY), 1, 0);
    repeat (2) @(negedge Clk);
`ifdef CANVAS_DROP_CNT_EN
    exp_drop = 3;
`else
    exp_drop = 0;
`endif
    check("drop_mid_stream", int'(drop_cnt), exp_drop);
    check("busy_mid_stream", int'(busy), 1);
    wait_stream("mid");
    wait_idle("mid_clear");
    model_clear();
    check("drop_after_clear", int'(drop_cnt), 0);
    scan("mid_clear");

    px = cell_px(10, OX);
    py = cell_px(10, OY);
    void'(to_cell(px, py, cx, cy));
    model_stamp(cx, cy, 0);
    pulse_vs(px, py, 1, 0);
    stream_start = 1'b1;
    @(negedge Clk);
    stream_start = 1'b0;
    push_stream();
    ready_mode = 3;
    wait_stream("pend_stream");
    wait_idle("pend_stream");

    pulse_vs(cell_px(12, OX), cell_px(3, OY), 1, 0);
    clear_req = 1'b1;
    stream_start = 1'b1;
    @(negedge Clk);
    clear_req = 1'b0;
    stream_start = 1'b0;
    model_clear();
    push_stream();
    ready_mode = 2;
    wait_stream("pend_both");
    wait_idle("pend_both");
    check("drop_pend_both", int'(drop_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
